rename_table: RTL and testbench

RENAME_TABLE -- requirements
Module: rename_table

---
 rtl/rename_pkg.sv | 17 +
 rtl/rename_table_if.sv | 52 +++++
 rtl/rename_table_free_list.sv | 77 +++++++
 rtl/rename_table.sv | 109 ++++++++++
 tb/tb_rename_table.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared sizing, tag/index types and pointer helper for the register rename table.
package rename_pkg;

    localparam int DEF_NUM_ARCH = 32;
    localparam int DEF_NUM_PHYS = 64;
    localparam int PTAG_W       = $clog2(DEF_NUM_PHYS);
    localparam int ARCH_W       = $clog2(DEF_NUM_ARCH);

    typedef logic [PTAG_W-1:0] ptag_t;
    typedef logic [ARCH_W-1:0] arch_idx_t;

    // Circular-buffer increment for depths that need not be a power of two.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rename_table_if.sv
// Decode/writeback/commit bundle between the pipeline (master) and the rename table (slave).
interface rename_table_if
    import rename_pkg::*;
#(
    parameter int NUM_ARCH = DEF_NUM_ARCH,
    parameter int NUM_PHYS = DEF_NUM_PHYS
);

    localparam int IDX_W = $clog2(NUM_ARCH);
    localparam int TAG_W = $clog2(NUM_PHYS);

    logic             rename_valid;
    logic             rename_ready;
    logic [IDX_W-1:0] rs1_arch;
    logic [IDX_W-1:0] rs2_arch;
    logic [IDX_W-1:0] rd_arch;
    logic [TAG_W-1:0] rs1_ptag;
    logic [TAG_W-1:0] rs2_ptag;
    logic             rs1_ready;
    logic             rs2_ready;
    logic [TAG_W-1:0] rd_ptag;
    logic [TAG_W-1:0] rd_old_ptag;

    logic             wb_valid;
    logic [TAG_W-1:0] wb_ptag;

    logic             commit_valid;
    logic [IDX_W-1:0] commit_rd_arch;
    logic [TAG_W-1:0] commit_ptag;
    logic [TAG_W-1:0] commit_old_ptag;

    logic             flush;

    modport master (
        output rename_valid, rs1_arch, rs2_arch, rd_arch,
        output wb_valid, wb_ptag,
        output commit_valid, commit_rd_arch, commit_ptag, commit_old_ptag,
        output flush,
        input  rename_ready, rs1_ptag, rs2_ptag, rs1_ready, rs2_ready,
        input  rd_ptag, rd_old_ptag
    );

    modport slave (
        input  rename_valid, rs1_arch, rs2_arch, rd_arch,
        input  wb_valid, wb_ptag,
        input  commit_valid, commit_rd_arch, commit_ptag, commit_old_ptag,
        input  flush,
        output rename_ready, rs1_ptag, rs2_ptag, rs1_ready, rs2_ready,
        output rd_ptag, rd_old_ptag
    );

endinterface

// File: rtl/rename_table_free_list.sv
// Circular free list of physical tags: pop at head, push at tail, flush rewinds head to tail.
module free_list
    import rename_pkg::*;
#(
    parameter int NUM_ARCH = DEF_NUM_ARCH,
    parameter int NUM_PHYS = DEF_NUM_PHYS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pop_i,
    input  logic                         push_i,
    input  logic [$clog2(NUM_PHYS)-1:0]  push_tag_i,
    input  logic                         flush_i,
    output logic [$clog2(NUM_PHYS)-1:0]  head_tag_o,
    output logic [$clog2(NUM_PHYS-NUM_ARCH+1)-1:0] count_o
);

    localparam int TAG_W      = $clog2(NUM_PHYS);
    localparam int FREE_DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int PTR_W      = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;
    localparam int CNT_W      = $clog2(FREE_DEPTH + 1);

    logic [TAG_W-1:0] slot_q [FREE_DEPTH];
    logic [TAG_W-1:0] slot_d [FREE_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return PTR_W'(wrap_inc(int'(p), FREE_DEPTH));
    endfunction

    always_comb begin
        slot_d  = slot_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        if (push_i) begin
            slot_d[tail_q] = push_tag_i;
            tail_d         = next_ptr(tail_q);
        end
        if (pop_i) begin
            head_d = next_ptr(head_q);
        end
        // Every tag not mapped by the committed state sits in the FREE_DEPTH slots ending at tail.
        if (flush_i) begin
            head_d  = tail_d;
            count_d = CNT_W'(FREE_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FREE_DEPTH; i++) begin
                slot_q[i] <= TAG_W'(NUM_ARCH + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(FREE_DEPTH);
        end else begin
            slot_q  <= slot_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_i) begin
            assert (count_q != CNT_W'(FREE_DEPTH));
        end
    end

    assign head_tag_o = slot_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/rename_table.sv
// Speculative/committed register alias tables with ready bits and free-list based tag allocation.
module rename_table
    import rename_pkg::*;
#(
    parameter int NUM_ARCH = DEF_NUM_ARCH,
    parameter int NUM_PHYS = DEF_NUM_PHYS
) (
    input  logic          clk,
    input  logic          rst,
    rename_table_if.slave bus
);

    localparam int IDX_W      = $clog2(NUM_ARCH);
    localparam int TAG_W      = $clog2(NUM_PHYS);
    localparam int FREE_DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int CNT_W      = $clog2(FREE_DEPTH + 1);

    logic [TAG_W-1:0]    rat_q  [NUM_ARCH];
    logic [TAG_W-1:0]    rat_d  [NUM_ARCH];
    logic [TAG_W-1:0]    rrat_q [NUM_ARCH];
    logic [TAG_W-1:0]    rrat_d [NUM_ARCH];
    logic [NUM_PHYS-1:0] ready_q, ready_d;

    logic [IDX_W-1:0] src_arch [2];
    logic [TAG_W-1:0] src_ptag [2];
    logic             src_rdy  [2];

    logic [TAG_W-1:0] head_tag;
    logic [CNT_W-1:0] free_count;
    logic             can_rename;
    logic             fire;
    logic             push;

    assign src_arch[0] = bus.rs1_arch;
    assign src_arch[1] = bus.rs2_arch;

    // Sources read the pre-update RAT, so an instruction never sees its own destination.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_ptag[gi] = (src_arch[gi] == '0) ? '0 : rat_q[src_arch[gi]];
            assign src_rdy[gi]  = (src_arch[gi] == '0)
                                | ready_q[src_ptag[gi]]
                                | (bus.wb_valid && (bus.wb_ptag == src_ptag[gi]));
        end
    endgenerate

    assign can_rename = (free_count != '0);
    assign fire       = bus.rename_valid && can_rename && (bus.rd_arch != '0) && !bus.flush;
    assign push       = bus.commit_valid && (bus.commit_rd_arch != '0);

    assign bus.rename_ready = can_rename;
    assign bus.rs1_ptag     = src_ptag[0];
    assign bus.rs2_ptag     = src_ptag[1];
    assign bus.rs1_ready    = src_rdy[0];
    assign bus.rs2_ready    = src_rdy[1];
    assign bus.rd_ptag      = head_tag;
    assign bus.rd_old_ptag  = (bus.rd_arch == '0) ? '0 : rat_q[bus.rd_arch];

    free_list #(
        .NUM_ARCH (NUM_ARCH),
        .NUM_PHYS (NUM_PHYS)
    ) u_free_list (
        .clk        (clk),
        .rst        (rst),
        .pop_i      (fire),
        .push_i     (push),
        .push_tag_i (bus.commit_old_ptag),
        .flush_i    (bus.flush),
        .head_tag_o (head_tag),
        .count_o    (free_count)
    );

    always_comb begin
        rat_d   = rat_q;
        rrat_d  = rrat_q;
        ready_d = ready_q;
        if (push) begin
            rrat_d[bus.commit_rd_arch] = bus.commit_ptag;
        end
        // Recovery sees this cycle's retirement; every surviving mapping is already produced.
        if (bus.flush) begin
            rat_d   = rrat_d;
            ready_d = '1;
        end else begin
            if (bus.wb_valid && (bus.wb_ptag != '0)) begin
                ready_d[bus.wb_ptag] = 1'b1;
            end
            if (fire) begin
                rat_d[bus.rd_arch] = head_tag;
                ready_d[head_tag]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                rat_q[i]  <= TAG_W'(i);
                rrat_q[i] <= TAG_W'(i);
            end
            ready_q <= '1;
        end else begin
            rat_q   <= rat_d;
            rrat_q  <= rrat_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_rename_table.sv
// Directed scenarios plus random traffic checked against a queue-based rename model.
module tb_rename_table;
    import rename_pkg::*;

    localparam int NA = DEF_NUM_ARCH;
    localparam int NP = DEF_NUM_PHYS;
    localparam int FD = NP - NA;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rename_table_if bus ();

    rename_table dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: speculative/committed maps, ready bits, free list as a queue, and the last FD tags
    // written into the free list (which is exactly what a flush restores, oldest first).
    typedef struct {
        int rd;
        int ptag;
        int old;
    } inflight_t;

    int        m_rat  [NA];
    int        m_rrat [NA];
    bit        m_ready[NP];
    int        q_free [$];
    int        q_hist [$];
    inflight_t q_if   [$];
    bit        model_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_ptag(input int a);
        return (a == 0) ? 32'd0 : 32'(m_rat[a]);
    endfunction

    function automatic logic [31:0] exp_rdy(input int a, input logic [31:0] p);
        bit r;
        r = (a == 0) || m_ready[p] || (bus.wb_valid && (32'(bus.wb_ptag) == p));
        return 32'(r);
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NA; i++) begin
            m_rat[i]  = i;
            m_rrat[i] = i;
        end
        for (int i = 0; i < NP; i++) m_ready[i] = 1'b1;
        q_free.delete();
        q_hist.delete();
        q_if.delete();
        for (int t = NA; t < NP; t++) begin
            q_free.push_back(t);
            q_hist.push_back(t);
        end
        model_valid = 1'b1;
    endtask

    task automatic update_model();
        int rd;
        int tag;
        int old;
        bit fire;
        if (!rst_n) begin
            reset_model();
            return;
        end
        rd   = int'(bus.rd_arch);
        fire = bus.rename_valid && (q_free.size() > 0) && (rd != 0) && !bus.flush;
        tag  = 0;
        old  = m_rat[rd];
        if (fire) tag = q_free.pop_front();
        if (bus.commit_valid && (bus.commit_rd_arch != '0)) begin
            m_rrat[int'(bus.commit_rd_arch)] = int'(bus.commit_ptag);
            q_free.push_back(int'(bus.commit_old_ptag));
            q_hist.push_back(int'(bus.commit_old_ptag));
            void'(q_hist.pop_front());
        end
        if (bus.flush) begin
            m_rat = m_rrat;
            for (int i = 0; i < NP; i++) m_ready[i] = 1'b1;
            q_free = q_hist;
            q_if.delete();
        end else begin
            if (bus.wb_valid && (bus.wb_ptag != '0)) m_ready[int'(bus.wb_ptag)] = 1'b1;
            if (fire) begin
                m_rat[rd]    = tag;
                m_ready[tag] = 1'b0;
                q_if.push_back('{rd: rd, ptag: tag, old: old});
            end
        end
    endtask

    task automatic check_model();
        logic [31:0] e;
        if (!model_valid) return;
        chk("rename_ready", 32'(bus.rename_ready), 32'(q_free.size() > 0));
        e = exp_ptag(int'(bus.rs1_arch));
        chk("rs1_ptag", 32'(bus.rs1_ptag), e);
        chk("rs1_ready", 32'(bus.rs1_ready), exp_rdy(int'(bus.rs1_arch), e));
        e = exp_ptag(int'(bus.rs2_arch));
        chk("rs2_ptag", 32'(bus.rs2_ptag), e);
        chk("rs2_ready", 32'(bus.rs2_ready), exp_rdy(int'(bus.rs2_arch), e));
        chk("rd_old_ptag", 32'(bus.rd_old_ptag), exp_ptag(int'(bus.rd_arch)));
        if ((bus.rd_arch != '0) && (q_free.size() > 0))
            chk("rd_ptag", 32'(bus.rd_ptag), 32'(q_free[0]));
    endtask

    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.rename_valid    = 1'b0;
        bus.rs1_arch        = '0;
        bus.rs2_arch        = '0;
        bus.rd_arch         = '0;
        bus.wb_valid        = 1'b0;
        bus.wb_ptag         = '0;
        bus.commit_valid    = 1'b0;
        bus.commit_rd_arch  = '0;
        bus.commit_ptag     = '0;
        bus.commit_old_ptag = '0;
        bus.flush           = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic rename(input int rd, input int rs1, input int rs2);
        idle();
        bus.rename_valid = 1'b1;
        bus.rd_arch      = arch_idx_t'(rd);
        bus.rs1_arch     = arch_idx_t'(rs1);
        bus.rs2_arch     = arch_idx_t'(rs2);
    endtask

    initial begin
        inflight_t ent;
        idle();
        rst_n = 1'b0;
        @(negedge clk);

        // Reset state: identity mapping, all ready, allocation available
        do_reset();
        bus.rs1_arch = arch_idx_t'(7);
        bus.rs2_arch = arch_idx_t'(31);
        #1;
        chk("reset_rename_ready", 32'(bus.rename_ready), 32'd1);
        chk("reset_rs1_ptag", 32'(bus.rs1_ptag), 32'd7);
        chk("reset_rs2_ptag", 32'(bus.rs2_ptag), 32'd31);
        chk("reset_rs1_ready", 32'(bus.rs1_ready), 32'd1);
        tick();

        // First rename and next-cycle lookup
        rename(5, 5, 0);
        #1;
        chk("first_rs1_ptag", 32'(bus.rs1_ptag), 32'd5);
        chk("first_rs1_ready", 32'(bus.rs1_ready), 32'd1);
        chk("first_rd_ptag", 32'(bus.rd_ptag), 32'd32);
        chk("first_rd_old", 32'(bus.rd_old_ptag), 32'd5);
        tick();
        idle();
        bus.rs1_arch = arch_idx_t'(5);
        #1;
        chk("after_rs1_ptag", 32'(bus.rs1_ptag), 32'd32);
        chk("after_rs1_ready", 32'(bus.rs1_ready), 32'd0);
        tick();

        // Exhaust the free list; a stalled rename changes nothing
        do_reset();
        for (int i = 0; i < FD; i++) begin
            rename(1 + (i % (NA - 1)), 0, 0);
            tick();
        end
        idle();
        #1;
        chk("empty_rename_ready", 32'(bus.rename_ready), 32'd0);
        rename(7, 7, 0);
        #1;
        chk("stall_rs1_ptag", 32'(bus.rs1_ptag), 32'd38);
        chk("stall_rd_old", 32'(bus.rd_old_ptag), 32'd38);
        tick();
        idle();
        bus.rs1_arch = arch_idx_t'(7);
        #1;
        chk("post_stall_rs1_ptag", 32'(bus.rs1_ptag), 32'd38);
        chk("post_stall_rs1_ready", 32'(bus.rs1_ready), 32'd0);
        chk("post_stall_ready", 32'(bus.rename_ready), 32'd0);
        tick();

        // Writeback bypass, then the ready bit sticks
        do_reset();
        rename(3, 0, 0);
        tick();
        idle();
        bus.wb_valid = 1'b1;
        bus.wb_ptag  = ptag_t'(32);
        bus.rs1_arch = arch_idx_t'(3);
        #1;
        chk("bypass_rs1_ptag", 32'(bus.rs1_ptag), 32'd32);
        chk("bypass_rs1_ready", 32'(bus.rs1_ready), 32'd1);
        tick();
        idle();
        bus.rs1_arch = arch_idx_t'(3);
        #1;
        chk("held_rs1_ready", 32'(bus.rs1_ready), 32'd1);
        tick();

        // Commit then flush: committed map restored, free list rewound
        do_reset();
        rename(3, 0, 0);
        #1;
        chk("flush_seq_tag3", 32'(bus.rd_ptag), 32'd32);
        tick();
        rename(4, 0, 0);
        #1;
        chk("flush_seq_tag4", 32'(bus.rd_ptag), 32'd33);
        tick();
        idle();
        bus.commit_valid    = 1'b1;
        bus.commit_rd_arch  = arch_idx_t'(3);
        bus.commit_ptag     = ptag_t'(32);
        bus.commit_old_ptag = ptag_t'(3);
        tick();
        idle();
        bus.flush = 1'b1;
        tick();
        idle();
        bus.rs1_arch = arch_idx_t'(3);
        bus.rs2_arch = arch_idx_t'(4);
        #1;
        chk("flush_rs1_ptag", 32'(bus.rs1_ptag), 32'd32);
        chk("flush_rs1_ready", 32'(bus.rs1_ready), 32'd1);
        chk("flush_rs2_ptag", 32'(bus.rs2_ptag), 32'd4);
        tick();
        for (int j = 0; j < FD; j++) begin
            rename(1, 0, 0);
            #1;
            chk("flush_alloc", 32'(bus.rd_ptag), (j == FD - 1) ? 32'd3 : 32'(33 + j));
            tick();
        end
        idle();
        #1;
        chk("flush_alloc_empty", 32'(bus.rename_ready), 32'd0);
        tick();

        // rd=0 / rs=0 and commit rd=0 are no-ops on the free list
        do_reset();
        rename(0, 0, 0);
        #1;
        chk("zero_rs1_ptag", 32'(bus.rs1_ptag), 32'd0);
        chk("zero_rs1_ready", 32'(bus.rs1_ready), 32'd1);
        chk("zero_rs2_ready", 32'(bus.rs2_ready), 32'd1);
        tick();
        rename(9, 0, 0);
        #1;
        chk("zero_no_pop", 32'(bus.rd_ptag), 32'd32);
        tick();
        idle();
        bus.commit_valid    = 1'b1;
        bus.commit_rd_arch  = '0;
        bus.commit_ptag     = ptag_t'(50);
        bus.commit_old_ptag = ptag_t'(50);
        tick();
        for (int i = 0; i < FD - 1; i++) begin
            rename(2, 0, 0);
            tick();
        end
        idle();
        #1;
        chk("zero_commit_count", 32'(bus.rename_ready), 32'd0);
        tick();

        // Reset wins over flush, commit and rename in the same cycle
        do_reset();
        rename(2, 0, 0);
        tick();
        rename(6, 0, 0);
        bus.flush           = 1'b1;
        bus.commit_valid    = 1'b1;
        bus.commit_rd_arch  = arch_idx_t'(2);
        bus.commit_ptag     = ptag_t'(32);
        bus.commit_old_ptag = ptag_t'(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rename(1, 2, 6);
        #1;
        chk("rst_over_ready", 32'(bus.rename_ready), 32'd1);
        chk("rst_over_rs1", 32'(bus.rs1_ptag), 32'd2);
        chk("rst_over_rs2", 32'(bus.rs2_ptag), 32'd6);
        chk("rst_over_rdy", 32'(bus.rs1_ready), 32'd1);
        chk("rst_over_alloc", 32'(bus.rd_ptag), 32'd32);
        tick();

        // Random traffic with in-order commits of previously renamed instructions
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            idle();
            bus.rename_valid = ($urandom_range(99) < 70);
            bus.rs1_arch     = arch_idx_t'($urandom_range(NA - 1));
            bus.rs2_arch     = arch_idx_t'($urandom_range(NA - 1));
            bus.rd_arch      = arch_idx_t'($urandom_range(NA - 1));
            bus.wb_valid     = ($urandom_range(99) < 40);
            if ((q_if.size() > 0) && ($urandom_range(1) == 1))
                bus.wb_ptag = ptag_t'(q_if[$urandom_range(q_if.size() - 1)].ptag);
            else
                bus.wb_ptag = ptag_t'($urandom_range(NP - 1));
            if ((q_if.size() > 0) && ($urandom_range(99) < 35)) begin
                ent = q_if.pop_front();
                bus.commit_valid    = 1'b1;
                bus.commit_rd_arch  = arch_idx_t'(ent.rd);
                bus.commit_ptag     = ptag_t'(ent.ptag);
                bus.commit_old_ptag = ptag_t'(ent.old);
            end else if ($urandom_range(99) < 5) begin
                bus.commit_valid    = 1'b1;
                bus.commit_rd_arch  = '0;
                bus.commit_ptag     = ptag_t'($urandom_range(NP - 1));
                bus.commit_old_ptag = ptag_t'($urandom_range(NP - 1));
            end
            bus.flush = ($urandom_range(99) < 2);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
